// File: rtl/bcast_round_sequencer_pkg.sv
// bcast_round_sequencer_pkg: shared state encoding, filter codes and padding map for the broadcast round sequencer
package bcast_round_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_POS   = 3'd1,
        S_ARM   = 3'd2,
        S_RUN   = 3'd3,
        S_DRAIN = 3'd4,
        S_DONE  = 3'd5
    } state_e;

    localparam logic [1:0] FILT_1X1 = 2'd0;
    localparam logic [1:0] FILT_3X3 = 2'd1;
    localparam logic [1:0] FILT_5X5 = 2'd2;
    localparam logic [1:0] FILT_BAD = 2'd3;

    localparam int DRAIN_W = 4;

    // Padding is half the filter width minus one half: 1x1->0, 3x3->1, 5x5->2.
    function automatic logic [1:0] filter_padding(input logic [1:0] code);
        return (code == FILT_3X3) ? 2'd1 : (code == FILT_5X5) ? 2'd2 : 2'd0;
    endfunction

endpackage

// File: rtl/bcast_drain_timer.sv
// bcast_drain_timer: 4-bit load/count-down timer with zero flag used to hold off the allocator check
// Ports:
//   clk, rst     clock, asynchronous active-low reset
//   load_i       load load_val_i (wins over counting)
//   load_val_i   value to load
//   en_i         count down by one while non-zero
//   zero_o       counter is zero
module bcast_drain_timer
    import bcast_round_sequencer_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic [DRAIN_W-1:0] load_val_i,
    input  logic               en_i,
    output logic               zero_o
);

    logic [DRAIN_W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = load_i ? load_val_i : (en_i && cnt_q != '0) ? cnt_q - DRAIN_W'(1) : cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign zero_o = cnt_q == '0;

endmodule

// File: rtl/bcast_round_sequencer.sv
// bcast_round_sequencer: steps the image broadcaster through every filter position of one layer pass
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   start, abort             pass control from the layer controller
//   num_rounds, filter_code  pass configuration, latched on an accepted start
//   stall                    downstream backpressure, forces bcast_block
//   pos_valid, pos_advance   positioner handshake
//   bcast_round              broadcaster round-complete level
//   alloc_ready              allocators drained
//   bcast_rst, bcast_block, image_padding  broadcaster controls
//   round_idx, busy, done, aborted, cfg_err status
// Optional (BCAST_SEQ_PERF_EN): stall_cycles, round_cycles performance counters.
module bcast_round_sequencer
    import bcast_round_sequencer_pkg::*;
#(
    parameter int ROUND_W      = 16,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [ROUND_W-1:0] num_rounds,
    input  logic [1:0]         filter_code,
    input  logic               stall,
    input  logic               pos_valid,
    input  logic               bcast_round,
    input  logic               alloc_ready,
    output logic               pos_advance,
    output logic               bcast_rst,
    output logic               bcast_block,
    output logic [1:0]         image_padding,
    output logic [ROUND_W-1:0] round_idx,
    output logic               busy,
    output logic               done,
    output logic               aborted,
    output logic               cfg_err
`ifdef BCAST_SEQ_PERF_EN
    ,
    output logic [31:0]        stall_cycles,
    output logic [23:0]        round_cycles
`endif
);

    state_e             state_q, state_d;
    logic [ROUND_W-1:0] num_q, num_d;
    logic [ROUND_W-1:0] idx_q, idx_d;
    logic [1:0]         pad_q, pad_d;
    logic               prev_run_q;
    logic               pos_adv_q, pos_adv_d;
    logic               aborted_q, aborted_d;
    logic               cfg_err_q, cfg_err_d;
    logic               idle, bad_cfg, accept, last, timer_zero, timer_load;

    assign idle       = state_q == S_IDLE;
    assign bad_cfg    = filter_code == FILT_BAD;
    assign accept     = idle && start && !bad_cfg;
    // num_q is never zero outside IDLE/DONE, so the subtraction cannot wrap.
    assign last       = idx_q == num_q - ROUND_W'(1);
    assign timer_load = state_q == S_RUN && state_d == S_DRAIN;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start && !bad_cfg) state_d = (num_rounds == '0) ? S_DONE : S_POS;
            S_POS:   if (pos_valid) state_d = S_ARM;
            S_ARM:   state_d = S_RUN;
            // The first RUN cycle sees the previous round's flag, which clears on that edge.
            S_RUN:   if (prev_run_q && bcast_round) state_d = S_DRAIN;
            S_DRAIN: if (timer_zero && alloc_ready) state_d = last ? S_DONE : S_POS;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort && !idle) state_d = S_IDLE;
        num_d     = accept ? num_rounds : num_q;
        pad_d     = accept ? filter_padding(filter_code) : pad_q;
        idx_d     = accept ? '0 : (state_q == S_DRAIN && state_d == S_POS) ? idx_q + ROUND_W'(1) : idx_q;
        pos_adv_d = state_d == S_POS && state_q != S_POS;
        aborted_d = abort && !idle;
        cfg_err_d = idle && start && bad_cfg;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            num_q      <= '0;
            idx_q      <= '0;
            pad_q      <= '0;
            prev_run_q <= 1'b0;
            pos_adv_q  <= 1'b0;
            aborted_q  <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            num_q      <= num_d;
            idx_q      <= idx_d;
            pad_q      <= pad_d;
            prev_run_q <= state_q == S_RUN;
            pos_adv_q  <= pos_adv_d;
            aborted_q  <= aborted_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    bcast_drain_timer u_drain_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (timer_load),
        .load_val_i (DRAIN_W'(DRAIN_CYCLES)),
        .en_i       (state_q == S_DRAIN),
        .zero_o     (timer_zero)
    );

    assign pos_advance   = pos_adv_q;
    assign bcast_rst     = !(state_q == S_RUN || state_q == S_DRAIN);
    assign bcast_block   = state_q != S_RUN || stall;
    assign image_padding = pad_q;
    assign round_idx     = idx_q;
    assign busy          = !idle;
    assign done          = state_q == S_DONE;
    assign aborted       = aborted_q;
    assign cfg_err       = cfg_err_q;

`ifdef BCAST_SEQ_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [23:0] round_cnt_q, round_len_q;
    logic        in_round;

    assign in_round = state_q == S_RUN || state_q == S_DRAIN;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            round_cnt_q <= '0;
            round_len_q <= '0;
        end else begin
            if (accept) stall_cnt_q <= '0;
            else if (state_q == S_RUN && stall && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (state_q == S_ARM) round_cnt_q <= '0;
            else if (in_round) round_cnt_q <= round_cnt_q + 24'd1;
            // Only a normal exit from DRAIN records a length; aborted rounds are discarded.
            if (state_q == S_DRAIN && (state_d == S_POS || state_d == S_DONE)) round_len_q <= round_cnt_q + 24'd1;
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign round_cycles = round_len_q;
`endif

endmodule

// File: tb/tb_bcast_round_sequencer.sv
// tb_bcast_round_sequencer: randomized self-checking bench driven by a per-round timing model
module tb_bcast_round_sequencer;

    localparam int RW = 16;
    localparam int D  = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0, abort = 1'b0, stall = 1'b0;
    logic          pos_valid = 1'b0, bcast_round = 1'b0, alloc_ready = 1'b0;
    logic [RW-1:0] num_rounds = '0;
    logic [1:0]    filter_code = '0;
    logic          pos_advance, bcast_rst, bcast_block, busy, done, aborted, cfg_err;
    logic [1:0]    image_padding;
    logic [RW-1:0] round_idx;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bcast_round_sequencer #(.ROUND_W(RW), .DRAIN_CYCLES(D)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .num_rounds    (num_rounds),
        .filter_code   (filter_code),
        .stall         (stall),
        .pos_valid     (pos_valid),
        .bcast_round   (bcast_round),
        .alloc_ready   (alloc_ready),
        .pos_advance   (pos_advance),
        .bcast_rst     (bcast_rst),
        .bcast_block   (bcast_block),
        .image_padding (image_padding),
        .round_idx     (round_idx),
        .busy          (busy),
        .done          (done),
        .aborted       (aborted),
        .cfg_err       (cfg_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet_idle(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_aborted"}, 32'(aborted), 32'd0);
        chk({tag, "_pos_advance"}, 32'(pos_advance), 32'd0);
        chk({tag, "_bcast_rst"}, 32'(bcast_rst), 32'd1);
        chk({tag, "_bcast_block"}, 32'(bcast_block), 32'd1);
    endtask

    // Idle cycles with random abort: abort while idle must be ignored.
    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            start       = 1'b0;
            abort       = 1'($urandom);
            stall       = 1'($urandom);
            pos_valid   = 1'($urandom);
            bcast_round = 1'($urandom);
            alloc_ready = 1'($urandom);
            @(negedge clk);
            chk_quiet_idle("idle");
            chk("idle_cfg_err", 32'(cfg_err), 32'd0);
            next_cycle();
        end
        abort = 1'b0;
    endtask

    // One pass. kill: 0 none, 1 abort, 2 async reset, applied in round kill_round.
    // Round timing, cycle 0 = first POS cycle (pos_advance high):
    //   pos_valid first high at pv -> ARM at pv+1 -> RUN from r0=pv+2.
    //   bcast_round rises at r0+br (br>=1) -> DRAIN from d0=r0+br+1.
    //   alloc_ready first looked at in cycle d0+D; exit cycle ex = max(d0+D, ac).
    //   Next round (or DONE) starts at ex+1.
    task automatic run_pass(input int n, input logic [1:0] fc, input int kill, input int kill_round, input bit directed);
        int pv, br, ac, r0, d0, ex, kc;
        bit stale;
        start       = 1'b1;
        abort       = 1'b0;
        num_rounds  = RW'(n);
        filter_code = fc;
        @(negedge clk);
        chk("start_busy", 32'(busy), 32'd0);
        chk("start_cfg_err", 32'(cfg_err), 32'd0);
        next_cycle();
        start       = 1'b0;
        num_rounds  = RW'($urandom);
        filter_code = 2'($urandom);
        if (fc == 2'd3) begin
            @(negedge clk);
            chk("cfg_err_pulse", 32'(cfg_err), 32'd1);
            chk("cfg_err_busy", 32'(busy), 32'd0);
            chk("cfg_err_pos_advance", 32'(pos_advance), 32'd0);
            next_cycle();
            return;
        end
        if (n == 0) begin
            @(negedge clk);
            chk("zero_done", 32'(done), 32'd1);
            chk("zero_busy", 32'(busy), 32'd1);
            chk("zero_bcast_rst", 32'(bcast_rst), 32'd1);
            chk("zero_pos_advance", 32'(pos_advance), 32'd0);
            next_cycle();
            return;
        end
        for (int r = 0; r < n; r++) begin
            pv    = directed ? 0 : int'($urandom_range(0, 3));
            br    = directed ? 9 : int'($urandom_range(1, 10));
            stale = directed ? 1'b0 : 1'($urandom);
            r0    = pv + 2;
            d0    = r0 + br + 1;
            ac    = directed ? 0 : d0 + int'($urandom_range(0, D + 20));
            ex    = (ac > d0 + D) ? ac : d0 + D;
            kc    = (kill != 0 && r == kill_round) ? int'($urandom_range(0, ex)) : -1;
            for (int c = 0; c <= ex; c++) begin
                start       = 1'($urandom);
                num_rounds  = RW'($urandom);
                filter_code = 2'($urandom);
                stall       = 1'($urandom);
                abort       = kill == 1 && c == kc;
                pos_valid   = (c < pv) ? 1'b0 : (c == pv) ? 1'b1 : 1'($urandom);
                bcast_round = (c < r0) ? 1'($urandom) : (c == r0) ? stale :
                              (c < r0 + br) ? 1'b0 : (c == r0 + br) ? 1'b1 : 1'($urandom);
                alloc_ready = directed ? 1'b1 : (c >= ac) ? 1'b1 : (c < d0 + D) ? 1'($urandom) : 1'b0;
                @(negedge clk);
                chk("busy", 32'(busy), 32'd1);
                chk("pos_advance", 32'(pos_advance), 32'(c == 0));
                chk("bcast_rst", 32'(bcast_rst), 32'(!(c >= r0 && c <= ex)));
                chk("bcast_block", 32'(bcast_block), 32'((c >= r0 && c < d0) ? stall : 1'b1));
                chk("round_idx", 32'(round_idx), 32'(r));
                chk("padding", 32'(image_padding), 32'(fc));
                chk("done", 32'(done), 32'd0);
                chk("aborted", 32'(aborted), 32'd0);
                chk("cfg_err", 32'(cfg_err), 32'd0);
                if (c == kc && kill == 1) begin
                    next_cycle();
                    abort = 1'b0;
                    start = 1'b0;
                    @(negedge clk);
                    chk("abort_pulse", 32'(aborted), 32'd1);
                    chk("abort_done", 32'(done), 32'd0);
                    chk("abort_busy", 32'(busy), 32'd0);
                    chk("abort_bcast_rst", 32'(bcast_rst), 32'd1);
                    chk("abort_pos_advance", 32'(pos_advance), 32'd0);
                    next_cycle();
                    return;
                end
                if (c == kc && kill == 2) begin
                    start = 1'b0;
                    #2 rst = 1'b0;
                    #1;
                    chk("rst_busy", 32'(busy), 32'd0);
                    chk("rst_bcast_rst", 32'(bcast_rst), 32'd1);
                    chk("rst_bcast_block", 32'(bcast_block), 32'd1);
                    chk("rst_round_idx", 32'(round_idx), 32'd0);
                    chk("rst_padding", 32'(image_padding), 32'd0);
                    chk("rst_pos_advance", 32'(pos_advance), 32'd0);
                    chk("rst_done", 32'(done), 32'd0);
                    chk("rst_aborted", 32'(aborted), 32'd0);
                    next_cycle();
                    rst = 1'b1;
                    @(negedge clk);
                    chk_quiet_idle("post_rst");
                    next_cycle();
                    return;
                end
                next_cycle();
            end
        end
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_busy", 32'(busy), 32'd1);
        chk("done_bcast_rst", 32'(bcast_rst), 32'd1);
        chk("done_pos_advance", 32'(pos_advance), 32'd0);
        chk("done_round_idx", 32'(round_idx), 32'(n - 1));
        chk("done_padding", 32'(image_padding), 32'(fc));
        next_cycle();
    endtask

    initial begin
        int n, kill;
        logic [1:0] fc;
        start       = 1'b1;
        abort       = 1'b1;
        filter_code = 2'd3;
        #2 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_quiet_idle("reset");
            chk("reset_padding", 32'(image_padding), 32'd0);
            chk("reset_round_idx", 32'(round_idx), 32'd0);
            chk("reset_cfg_err", 32'(cfg_err), 32'd0);
        end
        next_cycle();
        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        idle_cycles(2);
        run_pass(3, 2'd1, 0, 0, 1'b1);
        idle_cycles(2);
        run_pass(0, 2'd2, 0, 0, 1'b0);
        idle_cycles(2);
        run_pass(2, 2'd3, 0, 0, 1'b0);
        idle_cycles(2);
        run_pass(4, 2'd0, 1, 1, 1'b0);
        idle_cycles(1);
        run_pass(2, 2'd2, 0, 0, 1'b0);
        idle_cycles(1);
        run_pass(3, 2'd2, 2, 1, 1'b0);
        idle_cycles(2);
        for (int p = 0; p < 30; p++) begin
            n    = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 5));
            fc   = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            kill = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
            run_pass(n, fc, kill, (n > 0) ? int'($urandom_range(0, n - 1)) : 0, 1'b0);
            idle_cycles(int'($urandom_range(1, 3)));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
